// File: rtl/input_signal_router_pkg.sv
// -----------------------------------------------------------------------------
// input_signal_router_pkg
//   Shared FFT definitions: default sample width, the sample type, and the
//   bit-reversal helper. The helper is a constant function, so the router and
//   the twiddle-index logic can both resolve indices at elaboration time.
// -----------------------------------------------------------------------------
package input_signal_router_pkg;

  localparam int SAMPLE_WIDTH = 16;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;

  // Mirror the low nbits of idx: bit j moves to bit nbits-1-j.
  function automatic int unsigned bit_reverse(input int unsigned idx,
                                              input int unsigned nbits);
    int unsigned r;
    r = 0;
    for (int unsigned j = 0; j < nbits; j++) begin
      if (idx[j]) r[nbits-1-j] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/input_signal_router_sample_register.sv
// -----------------------------------------------------------------------------
// input_signal_router_sample_register
//   One sample-wide register with synchronous active-low clear.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous clear, active low (clear wins over capture)
//   d   - sample to capture
//   q   - registered sample
// -----------------------------------------------------------------------------
module input_signal_router_sample_register
  import input_signal_router_pkg::*;
#(
  parameter int WIDTH = SAMPLE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: state uses non-blocking assignment so every register in the frame
  // samples its input from before the edge; the clear is tested inside the
  // clocked block, which makes it synchronous rather than asynchronous.
  always_ff @(posedge clk) begin
    if (!rst) q <= '0;
    else      q <= d;
  end

endmodule

// File: rtl/input_signal_router.sv
// -----------------------------------------------------------------------------
// input_signal_router
//   Front-end reordering stage of the radix-2 DIT FFT. Captures a full frame
//   of complex samples every cycle and presents it in bit-reversed index
//   order one cycle later. Pure permutation: values are copied bit-exact.
// Ports:
//   clk           - rising-edge clock
//   rst           - synchronous reset, active low; zeroes every output
//   input_sig_Re  - real parts, natural order      [D_WIDTH-1:0]
//   input_sig_Im  - imaginary parts, natural order [D_WIDTH-1:0]
//   output_sig_Re - real parts, bit-reversed order
//   output_sig_Im - imaginary parts, bit-reversed order
// -----------------------------------------------------------------------------
module input_signal_router #(
  parameter int D_WIDTH      = 64,
  parameter int LOG_2_WIDTH  = 6,
  parameter int SAMPLE_WIDTH = input_signal_router_pkg::SAMPLE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] input_sig_Re  [D_WIDTH-1:0],
  input  logic [SAMPLE_WIDTH-1:0] input_sig_Im  [D_WIDTH-1:0],
  output logic [SAMPLE_WIDTH-1:0] output_sig_Re [D_WIDTH-1:0],
  output logic [SAMPLE_WIDTH-1:0] output_sig_Im [D_WIDTH-1:0]
);

  import input_signal_router_pkg::*;

  // The bit-reversal only forms a permutation when the frame is a full
  // power of two of the index width.
  if (D_WIDTH != 2**LOG_2_WIDTH) begin : g_bad_width
    $error("input_signal_router: D_WIDTH (%0d) must equal 2**LOG_2_WIDTH (%0d)",
           D_WIDTH, 2**LOG_2_WIDTH);
  end

  // Each output lane is hard-wired to its source lane; the index is a
  // constant per generate iteration, so no multiplexing is built.
  for (genvar k = 0; k < D_WIDTH; k++) begin : g_lane
    localparam logic [LOG_2_WIDTH-1:0] SRC =
      LOG_2_WIDTH'(bit_reverse(k, LOG_2_WIDTH));

    input_signal_router_sample_register #(
      .WIDTH (SAMPLE_WIDTH)
    ) u_re (
      .clk (clk),
      .rst (rst),
      .d   (input_sig_Re[SRC]),
      .q   (output_sig_Re[k])
    );

    input_signal_router_sample_register #(
      .WIDTH (SAMPLE_WIDTH)
    ) u_im (
      .clk (clk),
      .rst (rst),
      .d   (input_sig_Im[SRC]),
      .q   (output_sig_Im[k])
    );
  end

endmodule

// File: tb/tb_input_signal_router.sv
// -----------------------------------------------------------------------------
// tb_input_signal_router
//   Self-checking bench for the bit-reversal input router (default 64 x 16).
// -----------------------------------------------------------------------------
module tb_input_signal_router;
  import input_signal_router_pkg::*;

  localparam int DW = 64;
  localparam int LW = 6;
  localparam int SW = 16;

  typedef logic [DW-1:0][SW-1:0] pframe_t;
  typedef struct packed {
    pframe_t re;
    pframe_t im;
  } exp_t;

  typedef struct {
    int          pat;
    logic        r;
    int          idx;
    logic [SW-1:0] er;
    logic [SW-1:0] ei;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] in_re  [DW-1:0];
  logic [SW-1:0] in_im  [DW-1:0];
  logic [SW-1:0] out_re [DW-1:0];
  logic [SW-1:0] out_im [DW-1:0];

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  input_signal_router #(
    .D_WIDTH      (DW),
    .LOG_2_WIDTH  (LW),
    .SAMPLE_WIDTH (SW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .input_sig_Re  (in_re),
    .input_sig_Im  (in_im),
    .output_sig_Re (out_re),
    .output_sig_Im (out_im)
  );

  // Reference mirror for 6-bit indices, written out bit by bit.
  function automatic logic [LW-1:0] rev6(input logic [LW-1:0] k);
    return {k[0], k[1], k[2], k[3], k[4], k[5]};
  endfunction

  // Stimulus patterns: 0 ramp, 1 Re ramp / Im ramp+100, 2 reversed ramp,
  // 3 full-scale markers on a background.
  function automatic pframe_t pat_frame(input int p, input bit im);
    pframe_t f;
    for (int i = 0; i < DW; i++) begin
      case (p)
        0:       f[i] = SW'(i);
        1:       f[i] = im ? SW'(100 + i) : SW'(i);
        2:       f[i] = SW'(63 - i);
        default: begin
          if (!im) f[i] = (i == 1) ? 16'h8000 : SW'(16'h1000 + i);
          else     f[i] = (i == 3) ? 16'hFFFF : SW'(16'h2000 + i);
        end
      endcase
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [SW-1:0] act,
                       input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a frame and push the frame the DUT should show after the next edge.
  task automatic drive(input pframe_t re, input pframe_t im, input logic r);
    exp_t e;
    for (int k = 0; k < DW; k++) begin
      in_re[k] = re[k];
      in_im[k] = im[k];
      e.re[k]  = r ? re[rev6(LW'(k))] : '0;
      e.im[k]  = r ? im[rev6(LW'(k))] : '0;
    end
    rst = r;
    sb_q.push_back(e);
  endtask

  task automatic drive_pat(input int p, input logic r);
    drive(pat_frame(p, 1'b0), pat_frame(p, 1'b1), r);
  endtask

  // Advance one edge, sample just after it, and compare the whole frame.
  task automatic step_and_score(input string name);
    exp_t e;
    int   bad;
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, got re0=%h expected a queued frame",
               name, out_re[0]);
      return;
    end
    e   = sb_q.pop_front();
    bad = -1;
    for (int k = 0; k < DW; k++) begin
      if (bad < 0 && (out_re[k] !== e.re[k] || out_im[k] !== e.im[k])) bad = k;
    end
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s lane %0d: got re=%h im=%h expected re=%h im=%h",
               name, bad, out_re[bad], out_im[bad], e.re[bad], e.im[bad]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t    vecs [13];
    pframe_t rr, ri;

    vecs[0]  = '{0, 1'b1, 0,  16'd0,     16'd0};
    vecs[1]  = '{0, 1'b1, 1,  16'd32,    16'd32};
    vecs[2]  = '{0, 1'b1, 2,  16'd16,    16'd16};
    vecs[3]  = '{0, 1'b1, 3,  16'd48,    16'd48};
    vecs[4]  = '{0, 1'b1, 32, 16'd1,     16'd1};
    vecs[5]  = '{0, 1'b1, 63, 16'd63,    16'd63};
    vecs[6]  = '{0, 1'b1, 12, 16'd12,    16'd12};
    vecs[7]  = '{1, 1'b1, 5,  16'd40,    16'd140};
    vecs[8]  = '{1, 1'b1, 1,  16'd32,    16'd132};
    vecs[9]  = '{2, 1'b1, 1,  16'd31,    16'd31};
    vecs[10] = '{3, 1'b1, 32, 16'h8000,  16'h2001};
    vecs[11] = '{3, 1'b1, 48, 16'h1003,  16'hFFFF};
    vecs[12] = '{0, 1'b0, 1,  16'd0,     16'd0};

    // Reset with arbitrary inputs: every lane must read zero.
    for (int k = 0; k < DW; k++) begin
      rr[k] = SW'($urandom);
      ri[k] = SW'($urandom);
    end
    drive(rr, ri, 1'b0);
    step_and_score("reset");
    check("reset_re0", out_re[0], 16'd0);
    check("reset_im63", out_im[63], 16'd0);

    // Table-driven vectors: full frame via scoreboard plus a fixed probe.
    for (int v = 0; v < 13; v++) begin
      drive_pat(vecs[v].pat, vecs[v].r);
      step_and_score($sformatf("vec%0d", v));
      check($sformatf("vec%0d_re[%0d]", v, vecs[v].idx), out_re[vecs[v].idx], vecs[v].er);
      check($sformatf("vec%0d_im[%0d]", v, vecs[v].idx), out_im[vecs[v].idx], vecs[v].ei);
    end

    // Streaming: frame A then frame B on consecutive edges.
    drive_pat(0, 1'b1);
    step_and_score("stream_a");
    check("stream_a_re1", out_re[1], 16'd32);
    drive_pat(2, 1'b1);
    step_and_score("stream_b");
    check("stream_b_re1", out_re[1], 16'd31);

    // Mid-stream reset, held for two edges, then release.
    drive_pat(0, 1'b1);
    step_and_score("mid_pre");
    drive_pat(0, 1'b0);
    step_and_score("mid_rst0");
    check("mid_rst0_re1", out_re[1], 16'd0);
    drive_pat(3, 1'b0);
    step_and_score("mid_rst1");
    check("mid_rst1_im48", out_im[48], 16'd0);
    drive_pat(2, 1'b1);
    step_and_score("mid_release");
    check("mid_release_re1", out_re[1], 16'd31);
    check("mid_release_im0", out_im[0], 16'd63);

    // Random frames against the model.
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < DW; k++) begin
        rr[k] = SW'($urandom);
        ri[k] = SW'($urandom);
      end
      drive(rr, ri, 1'b1);
      step_and_score($sformatf("random%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
